vme_bus_initiator: RTL

- Single-outstanding bus master for the VME-style register-bank interface (VMEAddr/VMERdMem/VMEWrMem/VMEWrData out; VMERdData/VMERdDone/VMEWrDone/VMEx Error in).
- Accepts one read or write command from a local valid/ready port and issues a one-cycle strobe to the bank.
- Waits for done, error or timeout, then returns a response on a valid/ready port.
- Used by test/sequencer logic and local CPUs to access generated register banks.

---
 rtl/vme_bus_initiator_if.sv | 39 +++
 rtl/vme_bus_initiator.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vme_bus_initiator_if.sv
// Bundle of the local command/response handshake and the VME-style register-bank bus
// used by vme_bus_initiator (master side) and by bank models or consumers (slave side).
interface vme_bus_initiator_if #(
    parameter int ADDR_W = 18
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [31:0]         cmd_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_rdata;
    logic [1:0]          rsp_status;
    logic                busy;
    logic [ADDR_W+1:2]   VMEAddr;
    logic [31:0]         VMEWrData;
    logic                VMERdMem;
    logic                VMEWrMem;
    logic [31:0]         VMERdData;
    logic                VMERdDone;
    logic                VMEWrDone;
    logic                VMERdError;
    logic                VMEWrError;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        input  VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status, busy,
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        output VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, busy,
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );
endinterface

// File: rtl/vme_bus_initiator.sv
// Single-outstanding initiator: takes one command, fires a one-cycle strobe at the bank,
// waits for done/error/timeout, and hands back a response. All outputs come from registers.
module vme_bus_initiator #(
    parameter int ADDR_W  = 18,
    parameter int TIMEOUT = 255
) (
    input  logic                   Clk,
    input  logic                   Rst,
    vme_bus_initiator_if.master    bus
);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_r;
    logic [15:0]         cnt_r;
    logic                we_r;
    logic [ADDR_W+1:2]   vme_addr_r;
    logic [31:0]         vme_wdata_r;
    logic                rd_mem_r;
    logic                wr_mem_r;
    logic                cmd_ready_r;
    logic                rsp_valid_r;
    logic                busy_r;
    logic [31:0]         rdata_r;
    logic [1:0]          status_r;
    logic                done_s;
    logic                err_s;

    // Only the completion pair belonging to the current operation is looked at
    always_comb begin
        done_s = 1'b0;
        err_s  = 1'b0;
        if (we_r) begin
            done_s = bus.VMEWrDone;
            err_s  = bus.VMEWrError;
        end else begin
            done_s = bus.VMERdDone;
            err_s  = bus.VMERdError;
        end
    end

    // Transaction sequencer with registered bus and response outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            we_r        <= 1'b0;
            vme_addr_r  <= '0;
            vme_wdata_r <= 32'd0;
            rd_mem_r    <= 1'b0;
            wr_mem_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            rdata_r     <= 32'd0;
            status_r    <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        we_r        <= bus.cmd_we;
                        vme_addr_r  <= bus.cmd_addr;
                        vme_wdata_r <= bus.cmd_wdata;
                        rd_mem_r    <= ~bus.cmd_we;
                        wr_mem_r    <= bus.cmd_we;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_STROBE;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_STROBE: begin
                    rd_mem_r <= 1'b0;
                    wr_mem_r <= 1'b0;
                    cnt_r    <= TIMEOUT_C;
                    state_r  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Error beats done in the same cycle; done beats the last timeout cycle
                    if (err_s) begin
                        status_r    <= 2'b01;
                        rdata_r     <= 32'd0;
                        rsp_valid_r <= 1'b1;
                        cnt_r       <= 16'd0;
                        state_r     <= ST_RESP;
                    end else if (done_s) begin
                        status_r    <= 2'b00;
                        rdata_r     <= we_r ? 32'd0 : bus.VMERdData;
                        rsp_valid_r <= 1'b1;
                        cnt_r       <= 16'd0;
                        state_r     <= ST_RESP;
                    end else if (cnt_r == 16'd1) begin
                        status_r    <= 2'b10;
                        rdata_r     <= 32'd0;
                        rsp_valid_r <= 1'b1;
                        cnt_r       <= 16'd0;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r       <= cnt_r - 16'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rdata_r     <= 32'd0;
                        status_r    <= 2'b00;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    rd_mem_r    <= 1'b0;
                    wr_mem_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    cnt_r       <= 16'd0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_rdata  = rdata_r;
    assign bus.rsp_status = status_r;
    assign bus.busy       = busy_r;
    assign bus.VMEAddr    = vme_addr_r;
    assign bus.VMEWrData  = vme_wdata_r;
    assign bus.VMERdMem   = rd_mem_r;
    assign bus.VMEWrMem   = wr_mem_r;
endmodule
